// File: rtl/mc_ctrl.sv
// Multicycle sequencing controller: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives all datapath mux selects and write strobes, and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic [1:0]       rd_sel,
    output logic [1:0]       wd_sel,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic             ext_zero,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic is_rtype, funct_ok, op_ok, legal, is_jr, retire;
    logic mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;

    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_JR);
        op_ok    = (opcode == OP_LW)   || (opcode == OP_SW)  || (opcode == OP_BEQ) ||
                   (opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_J)   ||
                   (opcode == OP_JAL);
        legal    = (is_rtype && funct_ok) || op_ok;
        is_jr    = is_rtype && (funct == FN_JR);
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        iord        = 1'b0;
        pc_sel      = 2'b00;
        rd_sel      = 2'b00;
        wd_sel      = 2'b00;
        alu_a_sel   = 1'b0;
        alu_b_sel   = 2'b00;
        ext_zero    = 1'b0;
        alu_op      = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_b_sel = 2'b01;
                if (mem_rdy) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            // ALU speculatively forms the branch target so EXEC can use ALUOut.
            S_DECODE: begin
                alu_b_sel = 2'b11;
                if (!legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_write_c = 1'b1;
                    pc_sel     = 2'b10;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_write_c = 1'b1;
                        rd_sel      = 2'b10;
                        wd_sel      = 2'b10;
                    end
                end else if (is_jr) begin
                    pc_write_c = 1'b1;
                    pc_sel     = 2'b11;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_a_sel = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_b_sel = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_ORI: begin
                        alu_b_sel = 2'b10;
                        ext_zero  = 1'b1;
                        alu_op    = 2'b11;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_b_sel = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        pc_sel     = 2'b01;
                        pc_write_c = zero;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
                mem_we_c  = (opcode == OP_SW);
                if (mem_rdy) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write_c = 1'b1;
                if (is_rtype) begin
                    rd_sel = 2'b01;
                end else if (opcode == OP_LW) begin
                    wd_sel = 2'b01;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by rst so an abandoned instruction cannot write anything.
    always_comb begin
        mem_req   = mem_req_c   & ~rst;
        mem_we    = mem_we_c    & ~rst;
        ir_write  = ir_write_c  & ~rst;
        pc_write  = pc_write_c  & ~rst;
        reg_write = reg_write_c & ~rst;
        illegal   = illegal_c   & ~rst;
        instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: steps instructions cycle by cycle and checks state,
// every control output and the retire counter against hand-computed vectors.
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_rdy = 1'b0;
    logic             mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0]       pc_sel, rd_sel, wd_sel, alu_b_sel, alu_op;
    logic             alu_a_sel, ext_zero, illegal;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] expRet = '0;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .reg_write(reg_write), .rd_sel(rd_sel), .wd_sel(wd_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .ext_zero(ext_zero),
        .alu_op(alu_op), .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk(
        input logic mreq, mwe, io, irw, pcw, input logic [1:0] pcs,
        input logic rw, input logic [1:0] rds, wds, input logic aa,
        input logic [1:0] ab, input logic ez, input logic [1:0] aop, input logic ill);
        return {mreq, mwe, io, irw, pcw, pcs, rw, rds, wds, aa, ab, ez, aop, ill};
    endfunction

    logic [18:0] ctlObs;
    assign ctlObs = {mem_req, mem_we, iord, ir_write, pc_write, pc_sel, reg_write,
                     rd_sel, wd_sel, alu_a_sel, alu_b_sel, ext_zero, alu_op, illegal};

    localparam logic [18:0] F_RDY  = mk(1,0,0,1,1,0,0,0,0,0,1,0,0,0);
    localparam logic [18:0] F_WAIT = mk(1,0,0,0,0,0,0,0,0,0,1,0,0,0);
    localparam logic [18:0] D_GEN  = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    localparam logic [18:0] D_J    = mk(0,0,0,0,1,2,0,0,0,0,3,0,0,0);
    localparam logic [18:0] D_JAL  = mk(0,0,0,0,1,2,1,2,2,0,3,0,0,0);
    localparam logic [18:0] D_JR   = mk(0,0,0,0,1,3,0,0,0,0,3,0,0,0);
    localparam logic [18:0] D_ILL  = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,1);
    localparam logic [18:0] E_R    = mk(0,0,0,0,0,0,0,0,0,1,0,0,2,0);
    localparam logic [18:0] E_ADD  = mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    localparam logic [18:0] E_ORI  = mk(0,0,0,0,0,0,0,0,0,1,2,1,3,0);
    localparam logic [18:0] E_BQ1  = mk(0,0,0,0,1,1,0,0,0,1,0,0,1,0);
    localparam logic [18:0] E_BQ0  = mk(0,0,0,0,0,1,0,0,0,1,0,0,1,0);
    localparam logic [18:0] M_LW   = mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] M_SW   = mk(1,1,1,0,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] W_R    = mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0);
    localparam logic [18:0] W_LW   = mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0);
    localparam logic [18:0] W_I    = mk(0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    localparam logic [18:0] STROBES = mk(1,1,0,1,1,0,1,0,0,0,0,0,0,0);

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_OR = 6'b100101, FN_JR = 6'b001000,
                           FN_BAD = 6'b000000;

    localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check before the next rising edge.
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input logic [2:0] expState,
                                 input logic [18:0] expCtl, input logic ret);
        @(negedge clk);
        rst = 1'b0; opcode = op; funct = fn; zero = z; mem_rdy = rdy;
        #1;
        checkOutput({tag, " state"}, 32'(state), 32'(expState));
        checkOutput({tag, " ctl"}, 32'(ctlObs), 32'(expCtl));
        checkOutput({tag, " instret"}, 32'(instret), 32'(expRet));
        if (ret) expRet = expRet + 1'b1;
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst = 1'b1; mem_rdy = 1'b0;
        #1;
        expRet = '0;
        checkOutput({tag, " state"}, 32'(state), 32'(FE));
        checkOutput({tag, " strobes"}, 32'(ctlObs & STROBES), 32'h0);
        checkOutput({tag, " instret"}, 32'(instret), 32'h0);
    endtask

    initial begin
        applyReset("por");

        applyStimulus("add F",  OP_R, FN_ADD, 0, 1, FE, F_RDY, 0);
        applyStimulus("add D",  OP_R, FN_ADD, 0, 0, DE, D_GEN, 0);
        applyStimulus("add E",  OP_R, FN_ADD, 0, 0, EX, E_R,   0);
        applyStimulus("add W",  OP_R, FN_ADD, 0, 0, WB, W_R,   1);
        applyStimulus("lw F",   OP_LW, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("lw D",   OP_LW, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("lw E",   OP_LW, 0, 0, 1, EX, E_ADD, 0);
        applyStimulus("lw M",   OP_LW, 0, 0, 1, ME, M_LW,  0);
        applyStimulus("lw W",   OP_LW, 0, 0, 1, WB, W_LW,  1);
        applyStimulus("sw F",   OP_SW, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("sw D",   OP_SW, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("sw E",   OP_SW, 0, 0, 1, EX, E_ADD, 0);
        applyStimulus("sw M",   OP_SW, 0, 0, 1, ME, M_SW,  1);
        applyStimulus("beq1 F", OP_BEQ, 0, 1, 1, FE, F_RDY, 0);
        applyStimulus("beq1 D", OP_BEQ, 0, 1, 1, DE, D_GEN, 0);
        applyStimulus("beq1 E", OP_BEQ, 0, 1, 1, EX, E_BQ1, 1);
        applyStimulus("j F",    OP_J, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("j D",    OP_J, 0, 0, 1, DE, D_J,   1);
        applyStimulus("beq0 F", OP_BEQ, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("beq0 D", OP_BEQ, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("beq0 E", OP_BEQ, 0, 0, 1, EX, E_BQ0, 1);

        applyStimulus("lws F0", OP_LW, 0, 0, 0, FE, F_WAIT, 0);
        applyStimulus("lws F1", OP_LW, 0, 0, 0, FE, F_WAIT, 0);
        applyStimulus("lws F2", OP_LW, 0, 0, 1, FE, F_RDY,  0);
        applyStimulus("lws D",  OP_LW, 0, 0, 0, DE, D_GEN,  0);
        applyStimulus("lws E",  OP_LW, 0, 0, 0, EX, E_ADD,  0);
        for (int k = 0; k < 3; k++)
            applyStimulus("lws Mw", OP_LW, 0, 0, 0, ME, M_LW, 0);
        applyStimulus("lws M",  OP_LW, 0, 0, 1, ME, M_LW,  0);
        applyStimulus("lws W",  OP_LW, 0, 0, 1, WB, W_LW,  1);

        applyStimulus("jal F",  OP_JAL, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("jal D",  OP_JAL, 0, 0, 1, DE, D_JAL, 1);
        applyStimulus("jr F",   OP_R, FN_JR, 0, 1, FE, F_RDY, 0);
        applyStimulus("jr D",   OP_R, FN_JR, 0, 1, DE, D_JR,  1);
        applyStimulus("addi F", OP_ADDI, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("addi D", OP_ADDI, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("addi E", OP_ADDI, 0, 0, 1, EX, E_ADD, 0);
        applyStimulus("addi W", OP_ADDI, 0, 0, 1, WB, W_I,   1);
        applyStimulus("ori F",  OP_ORI, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("ori D",  OP_ORI, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("ori E",  OP_ORI, 0, 0, 1, EX, E_ORI, 0);
        applyStimulus("ori W",  OP_ORI, 0, 0, 1, WB, W_I,   1);
        applyStimulus("or F",   OP_R, FN_OR, 0, 1, FE, F_RDY, 0);
        applyStimulus("or D",   OP_R, FN_OR, 0, 1, DE, D_GEN, 0);
        applyStimulus("or E",   OP_R, FN_OR, 0, 1, EX, E_R,   0);
        applyStimulus("or W",   OP_R, FN_OR, 0, 1, WB, W_R,   1);

        applyStimulus("badop F", OP_BAD, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("badop D", OP_BAD, 0, 0, 1, DE, D_ILL, 0);
        applyStimulus("badfn F", OP_R, FN_BAD, 0, 1, FE, F_RDY, 0);
        applyStimulus("badfn D", OP_R, FN_BAD, 0, 1, DE, D_ILL, 0);
        checkOutput("count after illegal", 32'(instret), 32'd12);

        for (int k = 0; k < 4; k++) begin
            applyStimulus("wrap F", OP_J, 0, 0, 1, FE, F_RDY, 0);
            applyStimulus("wrap D", OP_J, 0, 0, 1, DE, D_J,   1);
        end
        @(posedge clk); #1;
        checkOutput("instret wrap", 32'(instret), 32'd0);

        applyStimulus("add2 F", OP_R, FN_ADD, 0, 1, FE, F_RDY, 0);
        applyStimulus("add2 D", OP_R, FN_ADD, 0, 1, DE, D_GEN, 0);
        applyStimulus("add2 E", OP_R, FN_ADD, 0, 1, EX, E_R,   0);
        applyStimulus("add2 W", OP_R, FN_ADD, 0, 1, WB, W_R,   1);
        applyStimulus("lwr F",  OP_LW, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("lwr D",  OP_LW, 0, 0, 1, DE, D_GEN, 0);
        applyStimulus("lwr E",  OP_LW, 0, 0, 1, EX, E_ADD, 0);
        applyStimulus("lwr M",  OP_LW, 0, 0, 0, ME, M_LW,  0);
        applyReset("midmem rst");
        applyStimulus("post rst F", OP_LW, 0, 0, 0, FE, F_WAIT, 0);
        applyStimulus("post rst F2", OP_LW, 0, 0, 1, FE, F_RDY, 0);
        applyStimulus("post rst D", OP_LW, 0, 0, 1, DE, D_GEN, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
